// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter (icache / dcache) in front of a single valid/ready memory port.
// One transaction outstanding at a time; the winning request is registered until completion.
`timescale 1ns/1ps
module mem_req_arbiter #(
  parameter int ADR_WIDTH  = 32,
  parameter int CPU_WIDTH  = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ic_valid,
  input  logic [ADR_WIDTH-1:0] i_ic_addr,
  output logic                 o_ic_ready,
  output logic [CPU_WIDTH-1:0] o_ic_rdata,
  input  logic                 i_dc_valid,
  input  logic                 i_dc_reqtyp,
  input  logic [ADR_WIDTH-1:0] i_dc_addr,
  input  logic [CPU_WIDTH-1:0] i_dc_wdata,
  input  logic [1:0]           i_dc_size,
  output logic                 o_dc_ready,
  output logic [CPU_WIDTH-1:0] o_dc_rdata,
  output logic                 o_mem_valid,
  output logic                 o_mem_reqtyp,
  output logic [ADR_WIDTH-1:0] o_mem_addr,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [1:0]           o_mem_size,
  input  logic                 i_mem_ready,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata,
  output logic                 o_busy,
  output logic                 o_gnt_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic                   gnt_q;
  logic                   req_typ_q;
  logic [ADR_WIDTH-1:0]   req_addr_q;
  logic [CPU_WIDTH-1:0]   req_wdata_q;
  logic [1:0]             req_size_q;
  logic                   any_req;
  logic                   winner;
  logic                   done;

  // gnt_q doubles as last_gnt: both are written with the winner on every grant.
  always_comb begin
    any_req = i_ic_valid | i_dc_valid;
    winner  = i_dc_valid;
    if (i_ic_valid && i_dc_valid) begin
      winner = (FIXED_PRIO != 0) ? 1'b1 : ~gnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req)     state_d = BUSY;
      BUSY: if (i_mem_ready) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      req_typ_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_size_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        gnt_q <= winner;
        if (winner) begin
          req_typ_q   <= i_dc_reqtyp;
          req_addr_q  <= i_dc_addr;
          req_wdata_q <= i_dc_wdata;
          req_size_q  <= i_dc_size;
        end else begin
          req_typ_q   <= 1'b0;
          req_addr_q  <= i_ic_addr;
          req_wdata_q <= '0;
          req_size_q  <= 2'd3;
        end
      end
    end
  end

  assign o_busy       = (state_q == BUSY);
  assign o_gnt_id     = gnt_q;
  assign o_mem_valid  = o_busy;
  assign o_mem_reqtyp = req_typ_q;
  assign o_mem_addr   = req_addr_q;
  assign o_mem_wdata  = req_wdata_q;
  assign o_mem_size   = req_size_q;

  // Completion is routed combinationally; i_mem_ready outside BUSY is ignored.
  assign done       = o_busy & i_mem_ready;
  assign o_ic_ready = done & ~gnt_q;
  assign o_dc_ready = done & gnt_q;
  assign o_ic_rdata = o_ic_ready ? i_mem_rdata : '0;
  assign o_dc_rdata = o_dc_ready ? i_mem_rdata : '0;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single memory-side valid/ready port between the instruction-fetch requester (icache) and the load/store requester (dcache/LSU).
- Sits between both caches and the AXI bridge.
- Holds one outstanding transaction at a time, registering the winning request.
- Arbitrates round-robin by default; an optional mode gives the dcache fixed priority.
- Routes the completion pulse and read data back to the winner only.

Parameters:
- ADR_WIDTH, 32, address width.
- CPU_WIDTH, 64, data width.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = dcache always wins ties.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_ic_valid  input  1  icache read request
- i_ic_addr  input  ADR_WIDTH  icache address
- o_ic_ready  output  1  one-cycle completion pulse to icache
- o_ic_rdata  output  CPU_WIDTH  icache read data, valid while o_ic_ready=1
- i_dc_valid  input  1  dcache request
- i_dc_reqtyp  input  1  0 = read, 1 = write
- i_dc_addr  input  ADR_WIDTH  dcache address
- i_dc_wdata  input  CPU_WIDTH  write data
- i_dc_size  input  2  0 = B, 1 = H, 2 = W, 3 = D
- o_dc_ready  output  1  one-cycle completion pulse to dcache
- o_dc_rdata  output  CPU_WIDTH  dcache read data, valid while o_dc_ready=1
- o_mem_valid  output  1  request to memory bridge
- o_mem_reqtyp  output  1  registered request type
- o_mem_addr  output  ADR_WIDTH  registered address
- o_mem_wdata  output  CPU_WIDTH  registered write data
- o_mem_size  output  2  registered size
- i_mem_ready  input  1  bridge completion pulse
- i_mem_rdata  input  CPU_WIDTH  bridge read data
- o_busy  output  1  transaction outstanding
- o_gnt_id  output  1  current/last grant: 0 = icache, 1 = dcache

Behaviour:
- Reset (async, i_rst_n=0):
  - state = IDLE.
  - All request registers = 0.
  - last_gnt = 0, so the first tie in round-robin mode goes to dcache.
  - Every output = 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any i_*_valid=1, pick a winner:
    - Only one requester valid: that requester wins.
    - Both valid, FIXED_PRIO=1: dcache wins.
    - Both valid, FIXED_PRIO=0: the requester not equal to last_gnt wins.
  - On the clock edge: latch the winner's fields into the request registers, set gnt_id and last_gnt = winner, go to BUSY.
  - An icache grant latches reqtyp=0, size=3, wdata=0.
- BUSY:
  - o_mem_valid=1 and o_mem_* driven from the registers, held stable until i_mem_ready.
  - When i_mem_ready=1: the ready of the granted requester = 1 combinationally that same cycle, with its rdata = i_mem_rdata; next state = IDLE.
  - The non-granted ready is always 0.
  - Both o_*_rdata are 0 whenever their ready is 0.
- Latency and throughput:
  - Request sampled in IDLE at cycle N; o_mem_valid first high at N+1.
  - Minimum accept-to-completion is 1 cycle after o_mem_valid rises.
  - Back-to-back requests take at least 2 cycles each; IDLE always lasts at least one cycle between transactions.
- Requesters hold valid and fields until their ready pulse.
- While BUSY, requester inputs are ignored; the latched copy is used.
  - A requester that drops valid mid-transaction (e.g. LSU suppressed by exception/interrupt) still receives its ready pulse, which it must discard.
- i_mem_ready while IDLE: ignored, no ready pulse generated.
- o_busy = (state == BUSY).
- o_gnt_id holds its value after completion until the next grant.
- A losing requester keeps valid high and is granted in the IDLE cycle following completion:
  - round-robin: guaranteed, since last_gnt now points to the other requester;
  - fixed priority: can starve while dcache requests continuously.
- Reset asserted mid-BUSY: transaction abandoned, all outputs 0 immediately (async). The bridge is reset by the same signal.

Test Plan:
- Reset, then i_ic_valid=1, addr=0x80000000 → o_mem_valid=1 next cycle with addr 0x80000000, reqtyp=0, size=3; i_mem_ready with rdata=0x1234 → o_ic_ready=1, o_ic_rdata=0x1234 same cycle, o_dc_ready=0.
- Both valid at reset-exit, FIXED_PRIO=0 → dcache first (o_gnt_id=1), icache granted in the IDLE cycle after dcache completes; repeat with both held → grants alternate 1,0,1,0.
- FIXED_PRIO=1, both held valid over 4 transactions → all grants dcache, icache never granted.
- Dcache write reqtyp=1, addr=0x80001008, wdata=0xDEADBEEF, size=2; change i_dc_* fields during BUSY → o_mem_* stay at latched values until i_mem_ready, 5-cycle bridge stall.
- Dcache drops i_dc_valid while BUSY → transaction still completes, o_dc_ready pulses once; spurious i_mem_ready in IDLE → no ready pulse.
- Assert i_rst_n=0 during BUSY → o_mem_valid, o_busy, o_gnt_id go to 0 without a clock edge; after release, first tie grants dcache.
